clint_ctrl: RTL and testbench

//  Core-local interrupt/trap sequencer. Detects ecall/ebreak/mret in the decode stage and

---
 rtl/clint_ctrl_pkg.sv | 34 +++
 rtl/clint_ctrl.sv | 141 ++++++++++++++
 tb/tb_clint_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/clint_ctrl_pkg.sv
// rtl/clint_ctrl_pkg.sv - shared CSR addresses, trap encodings and state type for clint_ctrl
package clint_ctrl_pkg;

  localparam int ADDR_W = 32;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [31:0] CAUSE_ECALL      = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK     = 32'd3;
  localparam logic [31:0] CAUSE_TIMER_DFLT = 32'h8000_0007;
  localparam logic [31:0] CAUSE_EXT_DFLT   = 32'h8000_000B;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    S_MEPC    = 3'd1,
    S_MSTATUS = 3'd2,
    S_MCAUSE  = 3'd3,
    S_ASSERT  = 3'd4,
    S_MRET    = 3'd5
  } state_t;

  function automatic logic [ADDR_W-1:0] csr_addr(input logic [11:0] a);
    return {{(ADDR_W-12){1'b0}}, a};
  endfunction

endpackage

// File: rtl/clint_ctrl.sv
// rtl/clint_ctrl.sv - trap/interrupt sequencer driving the CSR clint write port and PC redirect
// CLINT_MIE_MASK_EN: when defined, async interrupts are also gated by mie.MTIE / mie.MEIE.
module clint_ctrl
  import clint_ctrl_pkg::*;
#(
  parameter int          INT_W       = 8,
  parameter logic [31:0] CAUSE_TIMER = CAUSE_TIMER_DFLT,
  parameter logic [31:0] CAUSE_EXT   = CAUSE_EXT_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INT_W-1:0]  int_flag_i,
  input  logic [31:0]       inst_i,
  input  logic [31:0]       inst_addr_i,
  input  logic              jump_flag_i,
  input  logic [31:0]       jump_addr_i,
  input  logic [31:0]       csr_mtvec_i,
  input  logic [31:0]       csr_mepc_i,
  input  logic [31:0]       csr_mstatus_i,
  input  logic [31:0]       csr_mie_i,
  input  logic              global_int_en_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [ADDR_W-1:0] raddr_o,
  output logic [31:0]       data_o,
  output logic              hold_flag_o,
  output logic              int_assert_o,
  output logic [31:0]       int_addr_o
);

  state_t      state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] ret_q, ret_d;
  logic        mret_q, mret_d;

  logic is_ecall, is_ebreak, is_mret, timer_req, ext_req, async_req;

  assign raddr_o = '0;

`ifdef CLINT_MIE_MASK_EN
  assign timer_req = int_flag_i[0] & csr_mie_i[7];
  assign ext_req   = (|int_flag_i[INT_W-1:1]) & csr_mie_i[11];
`else
  logic unused_mie;
  assign unused_mie = ^csr_mie_i;
  assign timer_req  = int_flag_i[0];
  assign ext_req    = |int_flag_i[INT_W-1:1];
`endif

  assign is_ecall  = (inst_i == INST_ECALL);
  assign is_ebreak = (inst_i == INST_EBREAK);
  assign is_mret   = (inst_i == INST_MRET);
  assign async_req = (timer_req | ext_req) & global_int_en_i;

  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    ret_d        = ret_q;
    mret_d       = mret_q;
    we_o         = 1'b0;
    waddr_o      = '0;
    data_o       = '0;
    hold_flag_o  = 1'b0;
    int_assert_o = 1'b0;
    int_addr_o   = '0;
    case (state_q)
      IDLE: begin
        if (is_ecall || is_ebreak) begin
          hold_flag_o = 1'b1;
          cause_d     = is_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
          ret_d       = inst_addr_i;
          mret_d      = 1'b0;
          state_d     = S_MEPC;
        end else if (is_mret) begin
          hold_flag_o = 1'b1;
          mret_d      = 1'b1;
          state_d     = S_MRET;
        end else if (async_req) begin
          // Return to the redirect target if ex is jumping, so the jump is not lost.
          hold_flag_o = 1'b1;
          cause_d     = timer_req ? CAUSE_TIMER : CAUSE_EXT;
          ret_d       = jump_flag_i ? jump_addr_i : inst_addr_i;
          mret_d      = 1'b0;
          state_d     = S_MEPC;
        end
      end
      S_MEPC: begin
        hold_flag_o = 1'b1;
        we_o        = 1'b1;
        waddr_o     = csr_addr(CSR_MEPC);
        data_o      = ret_q;
        state_d     = S_MSTATUS;
      end
      S_MSTATUS: begin
        hold_flag_o = 1'b1;
        we_o        = 1'b1;
        waddr_o     = csr_addr(CSR_MSTATUS);
        data_o      = {csr_mstatus_i[31:8], csr_mstatus_i[3], csr_mstatus_i[6:4], 1'b0,
                       csr_mstatus_i[2:0]};
        state_d     = S_MCAUSE;
      end
      S_MCAUSE: begin
        hold_flag_o = 1'b1;
        we_o        = 1'b1;
        waddr_o     = csr_addr(CSR_MCAUSE);
        data_o      = cause_q;
        state_d     = S_ASSERT;
      end
      S_MRET: begin
        hold_flag_o = 1'b1;
        we_o        = 1'b1;
        waddr_o     = csr_addr(CSR_MSTATUS);
        data_o      = {csr_mstatus_i[31:8], 1'b1, csr_mstatus_i[6:4], csr_mstatus_i[7],
                       csr_mstatus_i[2:0]};
        state_d     = S_ASSERT;
      end
      S_ASSERT: begin
        hold_flag_o  = 1'b1;
        int_assert_o = 1'b1;
        int_addr_o   = mret_q ? csr_mepc_i : csr_mtvec_i;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cause_q <= '0;
      ret_q   <= '0;
      mret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      ret_q   <= ret_d;
      mret_q  <= mret_d;
    end
  end

endmodule

// File: tb/tb_clint_ctrl.sv
// tb/tb_clint_ctrl.sv - scoreboard bench for clint_ctrl trap, interrupt, mret and reset sequences
module tb_clint_ctrl;
  import clint_ctrl_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  int_flag_i = '0;
  logic [31:0] inst_i = NOP;
  logic [31:0] inst_addr_i = '0;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic [31:0] csr_mtvec_i = 32'h200;
  logic [31:0] csr_mepc_i = '0;
  logic [31:0] csr_mstatus_i = '0;
  logic [31:0] csr_mie_i = '0;
  logic        global_int_en_i = 1'b0;
  logic        we_o, hold_flag_o, int_assert_o;
  logic [31:0] waddr_o, raddr_o, data_o, int_addr_o;

  clint_ctrl dut (
    .clk(clk), .rst(rst), .int_flag_i(int_flag_i), .inst_i(inst_i),
    .inst_addr_i(inst_addr_i), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
    .csr_mie_i(csr_mie_i), .global_int_en_i(global_int_en_i), .we_o(we_o),
    .waddr_o(waddr_o), .raddr_o(raddr_o), .data_o(data_o), .hold_flag_o(hold_flag_o),
    .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_assert;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;

  task automatic push_w(input logic [11:0] a, input logic [31:0] d);
    exp_t e;
    e.is_assert = 1'b0;
    e.addr      = {20'b0, a};
    e.data      = d;
    sb.push_back(e);
  endtask

  task automatic push_a(input logic [31:0] target);
    exp_t e;
    e.is_assert = 1'b1;
    e.addr      = target;
    e.data      = '0;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_hold"}, {31'b0, hold_flag_o}, 32'd0);
    chk({name, "_we"}, {31'b0, we_o}, 32'd0);
    chk({name, "_assert"}, {31'b0, int_assert_o}, 32'd0);
    chk({name, "_waddr"}, waddr_o, 32'd0);
    chk({name, "_data"}, data_o, 32'd0);
    chk({name, "_addr"}, int_addr_o, 32'd0);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) step(1);
    chk({name, "_pending"}, sb.size(), 32'd0);
  endtask

  // Monitor: every CSR write or redirect strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (we_o === 1'b1 || int_assert_o === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output we=%0b waddr=%h data=%h assert=%0b target=%h required=none",
                 we_o, waddr_o, data_o, int_assert_o, int_addr_o);
      end else begin
        m_e = sb.pop_front();
        if (m_e.is_assert) begin
          if (!(int_assert_o === 1'b1 && we_o === 1'b0 && int_addr_o === m_e.addr)) begin
            errors++;
            $display("FAIL redirect actual assert=%0b we=%0b addr=%h required assert=1 we=0 addr=%h",
                     int_assert_o, we_o, int_addr_o, m_e.addr);
          end
        end else if (!(we_o === 1'b1 && int_assert_o === 1'b0 && waddr_o === m_e.addr &&
                       data_o === m_e.data)) begin
          errors++;
          $display("FAIL csr_write actual we=%0b assert=%0b addr=%h data=%h required addr=%h data=%h",
                   we_o, int_assert_o, waddr_o, data_o, m_e.addr, m_e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    step(2);
    rst = 1'b0;
    chk_quiet("reset");
    chk("raddr", raddr_o, 32'd0);

    // 1: ecall at 0x100, MIE=1; hold from detect through redirect
    csr_mstatus_i = 32'h8; global_int_en_i = 1'b1; inst_addr_i = 32'h100;
    push_w(CSR_MEPC, 32'h100); push_w(CSR_MSTATUS, 32'h80);
    push_w(CSR_MCAUSE, 32'd11); push_a(32'h200);
    inst_i = INST_ECALL;
    #1 chk("ecall_hold_T", {31'b0, hold_flag_o}, 32'd1);
    step(1);
    inst_i = NOP;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ecall_hold_T%0d", i), {31'b0, hold_flag_o}, 32'd1);
      step(1);
    end
    chk("ecall_hold_T5", {31'b0, hold_flag_o}, 32'd0);
    drain("ecall");

    // ebreak gives mcause 3
    inst_addr_i = 32'h108;
    push_w(CSR_MEPC, 32'h108); push_w(CSR_MSTATUS, 32'h80);
    push_w(CSR_MCAUSE, 32'd3); push_a(32'h200);
    inst_i = INST_EBREAK; step(1); inst_i = NOP;
    drain("ebreak");

    // 2: timer interrupt while ex jumps to 0x340
    inst_addr_i = 32'h110; jump_flag_i = 1'b1; jump_addr_i = 32'h340;
    push_w(CSR_MEPC, 32'h340); push_w(CSR_MSTATUS, 32'h80);
    push_w(CSR_MCAUSE, 32'h8000_0007); push_a(32'h200);
    int_flag_i = 8'h01; step(1); int_flag_i = '0; jump_flag_i = 1'b0;
    drain("timer");

    // 3: mret with mepc=0x104, MPIE=1
    global_int_en_i = 1'b0; csr_mstatus_i = 32'h80; csr_mepc_i = 32'h104;
    push_w(CSR_MSTATUS, 32'h88); push_a(32'h104);
    inst_i = INST_MRET; step(1); inst_i = NOP;
    drain("mret");

    // mret wins over a simultaneous interrupt; MPIE=0 restores MIE=0
    global_int_en_i = 1'b1; csr_mstatus_i = 32'h0;
    push_w(CSR_MSTATUS, 32'h80); push_a(32'h104);
    inst_i = INST_MRET; int_flag_i = 8'h01; step(1);
    inst_i = NOP; int_flag_i = '0; global_int_en_i = 1'b0;
    drain("mret_prio");

    // 4: external interrupt masked by MIE=0, then taken
    int_flag_i = 8'h02; inst_addr_i = 32'h180;
    #1 chk("masked_hold", {31'b0, hold_flag_o}, 32'd0);
    step(3);
    chk("masked_hold_later", {31'b0, hold_flag_o}, 32'd0);
    csr_mstatus_i = 32'h8; global_int_en_i = 1'b1;
    push_w(CSR_MEPC, 32'h180); push_w(CSR_MSTATUS, 32'h80);
    push_w(CSR_MCAUSE, 32'h8000_000B); push_a(32'h200);
    step(1); int_flag_i = '0;
    drain("ext");

    // 5: reset during S_MSTATUS aborts before mcause
    inst_addr_i = 32'h120;
    push_w(CSR_MEPC, 32'h120); push_w(CSR_MSTATUS, 32'h80);
    inst_i = INST_ECALL; step(1); inst_i = NOP;
    step(1);
    rst = 1'b1; step(1); rst = 1'b0;
    chk_quiet("abort");
    step(4);
    chk("abort_idle_hold", {31'b0, hold_flag_o}, 32'd0);
    drain("abort");

`ifdef CLINT_MIE_MASK_EN
    // 6: timer pending but MTIE clear, then enabled
    inst_addr_i = 32'h1c0; csr_mie_i = '0; int_flag_i = 8'h01;
    #1 chk("mie_masked_hold", {31'b0, hold_flag_o}, 32'd0);
    step(3);
    push_w(CSR_MEPC, 32'h1c0); push_w(CSR_MSTATUS, 32'h80);
    push_w(CSR_MCAUSE, 32'h8000_0007); push_a(32'h200);
    csr_mie_i = 32'h80; step(1); int_flag_i = '0;
    drain("mie");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
